despachante_terminais: RTL and testbench

Sequential dispatcher sitting directly downstream of the terminal selector. It consumes the selector's two enable outputs (TERMINAL1_EN, TERMINAL2_EN), keeps a bounded count of waiting requests, and hands each request to a free, enabled terminal. Each terminal is then held busy for a fixed service time. It provides the occupancy and dispatch status that the display and alarm stages use.

---
 rtl/despachante_pkg.sv | 12 +
 rtl/terminal_atendimento.sv | 52 +++++
 rtl/despachante_terminais.sv | 73 +++++++
 tb/tb_despachante_terminais.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/despachante_pkg.sv
// Shared types and widths for the terminal dispatcher.
package despachante_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVING = 1'b1
    } term_state_t;

    localparam int COUNT_W = 4;
    localparam int TIMER_W = 4;

endpackage

// File: rtl/terminal_atendimento.sv
// One service terminal: IDLE/SERVING FSM with a down-counter holding it busy
// for SERVICE_CYCLES cycles after each START.
module terminal_atendimento
    import despachante_pkg::*;
#(
    parameter int SERVICE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic START,
    output logic BUSY
);

    localparam logic [TIMER_W-1:0] LOAD = TIMER_W'(SERVICE_CYCLES - 1);

    term_state_t        state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Timer holds the remaining cycles after the current one; zero means last cycle.
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = SERVING;
                    timer_next = LOAD;
                end
            end
            SERVING: begin
                if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end
        endcase
    end

    assign BUSY = (state == SERVING);

endmodule

// File: rtl/despachante_terminais.sv
// Dispatcher: bounded request counter, admission and terminal-1-priority dispatch
// into two service terminals, with registered status and pulse outputs.
module despachante_terminais
    import despachante_pkg::*;
#(
    parameter int SERVICE_CYCLES = 4,
    parameter int QUEUE_MAX      = 7
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               REQ,
    input  logic               TERMINAL1_EN,
    input  logic               TERMINAL2_EN,
    output logic [COUNT_W-1:0] QUEUE_COUNT,
    output logic               EMPTY,
    output logic               FULL,
    output logic               BUSY1,
    output logic               BUSY2,
    output logic               DISPATCH1,
    output logic               DISPATCH2,
    output logic               DROP
);

    localparam logic [COUNT_W-1:0] QMAX = COUNT_W'(QUEUE_MAX);

    logic [COUNT_W-1:0] count, count_next;
    logic               go1, go2, accepted;

    // A request arriving this edge is only counted; dispatch sees the old count.
    always_comb begin
        go1        = (count != '0) && TERMINAL1_EN && !BUSY1;
        go2        = TERMINAL2_EN && !BUSY2 && (count > {{(COUNT_W-1){1'b0}}, go1});
        accepted   = REQ && ((count < QMAX) || go1 || go2);
        count_next = count + {{(COUNT_W-1){1'b0}}, accepted}
                           - {{(COUNT_W-1){1'b0}}, go1}
                           - {{(COUNT_W-1){1'b0}}, go2};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count     <= '0;
            EMPTY     <= 1'b1;
            FULL      <= 1'b0;
            DISPATCH1 <= 1'b0;
            DISPATCH2 <= 1'b0;
            DROP      <= 1'b0;
        end else begin
            count     <= count_next;
            EMPTY     <= (count_next == '0);
            FULL      <= (count_next == QMAX);
            DISPATCH1 <= go1;
            DISPATCH2 <= go2;
            DROP      <= REQ && !accepted;
        end
    end

    assign QUEUE_COUNT = count;

    terminal_atendimento #(.SERVICE_CYCLES(SERVICE_CYCLES)) u_term1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (go1),
        .BUSY  (BUSY1)
    );

    terminal_atendimento #(.SERVICE_CYCLES(SERVICE_CYCLES)) u_term2 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (go2),
        .BUSY  (BUSY2)
    );

endmodule

// File: tb/tb_despachante_terminais.sv
// Directed bench for despachante_terminais with SERVICE_CYCLES=4, QUEUE_MAX=7.
module tb_despachante_terminais;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ = 1'b0;
    logic       TERMINAL1_EN = 1'b0;
    logic       TERMINAL2_EN = 1'b0;
    logic [3:0] QUEUE_COUNT;
    logic       EMPTY, FULL, BUSY1, BUSY2, DISPATCH1, DISPATCH2, DROP;

    int tests_run = 0;
    int tests_failed = 0;
    int busy_n, d1_n, drops;

    despachante_terminais #(.SERVICE_CYCLES(4), .QUEUE_MAX(7)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ          (REQ),
        .TERMINAL1_EN (TERMINAL1_EN),
        .TERMINAL2_EN (TERMINAL2_EN),
        .QUEUE_COUNT  (QUEUE_COUNT),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .BUSY1        (BUSY1),
        .BUSY2        (BUSY2),
        .DISPATCH1    (DISPATCH1),
        .DISPATCH2    (DISPATCH2),
        .DROP         (DROP)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
    endtask

    function automatic logic [10:0] status();
        return {QUEUE_COUNT, EMPTY, FULL, BUSY1, BUSY2, DISPATCH1, DISPATCH2, DROP};
    endfunction

    initial begin
        // Reset and idle
        @(negedge CLK);
        step();
        check_eq("reset_state", 32'(status()), 32'({4'd0, 7'b1000000}));
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("idle_after_reset", 32'(status()), 32'({4'd0, 7'b1000000}));
        end

        // Single request on terminal 1
        TERMINAL1_EN = 1'b1;
        REQ = 1'b1;
        step();
        check_eq("single_count1", 32'(QUEUE_COUNT), 32'd1);
        check_eq("single_empty0", 32'(EMPTY), 32'd0);
        check_eq("single_no_disp_yet", 32'(DISPATCH1), 32'd0);
        REQ = 1'b0;
        step();
        check_eq("single_disp1", 32'({DISPATCH1, DISPATCH2, BUSY1}), 32'b101);
        check_eq("single_count0", 32'(QUEUE_COUNT), 32'd0);
        busy_n = 1;
        d1_n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            busy_n += int'(BUSY1);
            d1_n += int'(DISPATCH1);
        end
        check_eq("single_busy_len", 32'(busy_n), 32'd4);
        check_eq("single_no_extra_disp", 32'(d1_n), 32'd0);
        TERMINAL1_EN = 1'b0;

        // Parallel dispatch of three queued requests
        REQ = 1'b1;
        for (int i = 0; i < 3; i++) step();
        REQ = 1'b0;
        check_eq("par_queued3", 32'(QUEUE_COUNT), 32'd3);
        TERMINAL1_EN = 1'b1;
        TERMINAL2_EN = 1'b1;
        step();
        check_eq("par_both_disp", 32'({DISPATCH1, DISPATCH2}), 32'b11);
        check_eq("par_count1", 32'(QUEUE_COUNT), 32'd1);
        check_eq("par_both_busy", 32'({BUSY1, BUSY2}), 32'b11);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("par_wait", 32'({DISPATCH1, DISPATCH2, BUSY1, QUEUE_COUNT}), 32'({3'b001, 4'd1}));
        end
        step();
        check_eq("par_idle_gap", 32'({DISPATCH1, BUSY1, BUSY2, QUEUE_COUNT}), 32'({3'b000, 4'd1}));
        step();
        check_eq("par_third_t1", 32'({DISPATCH1, DISPATCH2, QUEUE_COUNT, EMPTY}), 32'({2'b10, 4'd0, 1'b1}));
        TERMINAL1_EN = 1'b0;
        TERMINAL2_EN = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("par_drained", 32'({BUSY1, BUSY2, QUEUE_COUNT}), 32'd0);

        // Overflow with both terminals disabled
        REQ = 1'b1;
        drops = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            drops += int'(DROP);
            if (i == 6) check_eq("ovf_drop_not_yet", 32'(drops), 32'd0);
        end
        check_eq("ovf_count7", 32'(QUEUE_COUNT), 32'd7);
        check_eq("ovf_full", 32'(FULL), 32'd1);
        check_eq("ovf_drops2", 32'(drops), 32'd2);

        // Full queue with simultaneous dispatch: REQ admitted
        TERMINAL1_EN = 1'b1;
        step();
        check_eq("full_disp_nodrop", 32'({DROP, DISPATCH1}), 32'b01);
        check_eq("full_disp_count7", 32'({QUEUE_COUNT, FULL}), 32'({4'd7, 1'b1}));
        REQ = 1'b0;
        TERMINAL1_EN = 1'b0;

        // Asynchronous reset mid-service
        apply_reset();
        REQ = 1'b1;
        for (int i = 0; i < 4; i++) step();
        REQ = 1'b0;
        TERMINAL1_EN = 1'b1;
        step();
        TERMINAL1_EN = 1'b0;
        step();
        check_eq("mid_busy_count3", 32'({BUSY1, QUEUE_COUNT}), 32'({1'b1, 4'd3}));
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("async_reset_now", 32'(status()), 32'({4'd0, 7'b1000000}));
        @(negedge CLK);
        RST_N = 1'b1;
        TERMINAL1_EN = 1'b1;
        TERMINAL2_EN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("post_reset_quiet", 32'({DISPATCH1, DISPATCH2, BUSY1, BUSY2, QUEUE_COUNT}), 32'd0);
        end
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        check_eq("post_reset_req", 32'({DISPATCH1, QUEUE_COUNT}), 32'({1'b0, 4'd1}));
        step();
        check_eq("post_reset_disp", 32'({DISPATCH1, DISPATCH2, QUEUE_COUNT}), 32'({2'b10, 4'd0}));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
